spi_mitm_frame_modifier: RTL and testbench
==========================================

// Module: spi_mitm_frame_modifier
// PURPOSE
// Multi-channel, parametrised frame modifier for the SPI MITM datapath. Sits between the per-direction
// frame deserialisers (if0 MOSI, if1 MISO, ...) and the re-serialisers. Applies the selected MITM
// transformation per channel, gated by a channel mask and a frame-skip threshold. Buffers results in a
// per-channel FIFO; the mode is latched once per bus session so a button press never splits a session.
// PARAMETERS
// NUM_DATA_BITS   8       frame width in bits (>=1)
// NUM_CHANNELS    2       independent frame streams (ch0 = MOSI, ch1 = MISO by convention)
// FIFO_DEPTH      4       entries per channel FIFO (power of two, >=2)
// CNT_WIDTH       8       width of per-channel frame index / drop counters
// SUB_VALUE       8'h00   replacement frame for MODE_SUB (NUM_DATA_BITS wide)
// XOR_MASK        8'hff   mask for MODE_XOR (NUM_DATA_BITS wide)
// PORTS
// sys_clk         in   1                       system clock, all logic on rising edge
// rst_n           in   1                       asynchronous reset, active low
// session_active  in   1                       SS active, already synchronised to sys_clk
// mode_sel        in   3                       0 FWD, 1 SUB, 2 BLOCK, 3 ROT13, 4 XOR, 5-7 = FWD
// chan_mask       in   NUM_CHANNELS            bit c=1: channel c is modified; 0: always forwarded
// skip_frames     in   CNT_WIDTH               frames with index < skip_frames are forwarded unmodified
// in_valid        in   NUM_CHANNELS            one-cycle strobe per received frame
// in_data         in   NUM_CHANNELS*NUM_DATA_BITS  packed frames, ch c at [c*NUM_DATA_BITS +: NUM_DATA_BITS]
// out_ready       in   NUM_CHANNELS            consumer accepts head frame of channel c
// out_valid       out  NUM_CHANNELS            channel FIFO non-empty
// out_data        out  NUM_CHANNELS*NUM_DATA_BITS  FIFO head per channel, same packing as in_data
// active_mode     out  3                       mode latched for the current session
// overflow        out  NUM_CHANNELS            sticky: frame lost because FIFO full
// frame_cnt       out  NUM_CHANNELS*CNT_WIDTH  frames received this session, saturating
// BEHAVIOUR
// - Reset (rst_n=0, async): FIFOs empty, out_valid=0, out_data=0, active_mode=0, overflow=0, frame_cnt=0, stage regs clear.
// - Session start = rising edge of session_active (registered prev value). On that cycle: latch mode_sel
//   into active_mode, flush all FIFOs and stage regs, clear frame_cnt and overflow. in_valid on same cycle is dropped.
// - mode_sel changes outside a session start have no effect until the next start.
// - Pipeline per channel: in_valid -> stage register (transform applied) -> FIFO write next cycle.
//   Empty-FIFO latency in_valid to out_valid = 2 cycles. Channels are fully independent.
// - frame_cnt[c] increments on every in_valid[c] (incl. blocked), saturates at 2^CNT_WIDTH-1.
//   Frame index used for skip test = frame_cnt value before increment.
// - Modify condition: chan_mask[c] && index >= skip_frames. If false, frame is forwarded unchanged.
// - FWD: unchanged. SUB: SUB_VALUE. XOR: data ^ XOR_MASK. BLOCK: frame not enqueued (still counted).
// - ROT13: bits [7:0] only; 'A'-'Z' and 'a'-'z' rotated by 13 modulo 26, other codes unchanged;
//   bits above 7 pass through. If NUM_DATA_BITS<8, ROT13 behaves as FWD.
// - FIFO: write when stage valid; read when out_valid[c] && out_ready[c]. Full and read in same cycle:
//   write accepted. Full, no read: frame dropped, overflow[c] set until next session start or reset.
// - Pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH distinguishes full from empty.
// - out_data holds head value while out_valid=1 and not read; when empty out_data holds last head value.
// - Session end (session_active falling): no flush; remaining frames drain normally.
// - rst_n asserted mid-session: immediate clear as above; next session start required to latch a mode.
// TESTING
// - Reset, mode_sel=0, session start, ch0 frames 0xca,0x00 -> out_data ch0 0xca,0x00 two cycles after each strobe.
// - mode_sel=1, chan_mask=2'b01, skip_frames=1, ch0 0x9b,0x38; ch1 0x26 -> ch0 0x9b,0x00; ch1 0x26.
// - mode_sel=3, chan_mask=2'b11, ch0 'H'(0x48),'z'(0x7a),'5'(0x35) -> 0x55,0x6d,0x35; active_mode=3.
// - mode_sel=2, chan_mask=2'b10, ch1 0x4f,0x68,0x69 -> ch1 out_valid never set, frame_cnt ch1=3; ch0 unaffected.
// - out_ready=0, 5 frames into ch0 (DEPTH 4) -> first 4 held in order, overflow[0]=1; new session clears it.
// - Change mode_sel mid-session -> active_mode unchanged until next rising session_active; rst_n pulse mid-session empties FIFOs.

Source files
------------

// File: rtl/spi_mitm_frame_modifier_if.sv
// Bus bundle for the SPI MITM frame modifier: session/mode control, per-channel
// frame input strobes and per-channel FIFO output handshake plus status.
interface spi_mitm_frame_modifier_if #(
  parameter int NUM_DATA_BITS = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int CNT_WIDTH     = 8
);
  logic                                  session_active;
  logic [2:0]                            mode_sel;
  logic [NUM_CHANNELS-1:0]               chan_mask;
  logic [CNT_WIDTH-1:0]                  skip_frames;
  logic [NUM_CHANNELS-1:0]               in_valid;
  logic [NUM_CHANNELS*NUM_DATA_BITS-1:0] in_data;
  logic [NUM_CHANNELS-1:0]               out_ready;
  logic [NUM_CHANNELS-1:0]               out_valid;
  logic [NUM_CHANNELS*NUM_DATA_BITS-1:0] out_data;
  logic [2:0]                            active_mode;
  logic [NUM_CHANNELS-1:0]               overflow;
  logic [NUM_CHANNELS*CNT_WIDTH-1:0]     frame_cnt;

  modport master (
    output session_active, mode_sel, chan_mask, skip_frames, in_valid, in_data, out_ready,
    input  out_valid, out_data, active_mode, overflow, frame_cnt
  );

  modport slave (
    input  session_active, mode_sel, chan_mask, skip_frames, in_valid, in_data, out_ready,
    output out_valid, out_data, active_mode, overflow, frame_cnt
  );
endinterface

// File: rtl/spi_mitm_frame_modifier.sv
// Per-channel MITM frame transform (FWD/SUB/BLOCK/ROT13/XOR) with a one-cycle stage
// register feeding a small FIFO; mode latched at each rising edge of session_active.
module spi_mitm_frame_modifier #(
  parameter int                       NUM_DATA_BITS = 8,
  parameter int                       NUM_CHANNELS  = 2,
  parameter int                       FIFO_DEPTH    = 4,
  parameter int                       CNT_WIDTH     = 8,
  parameter logic [NUM_DATA_BITS-1:0] SUB_VALUE     = '0,
  parameter logic [NUM_DATA_BITS-1:0] XOR_MASK      = '1
) (
  input logic                     sys_clk,
  input logic                     rst_n,
  spi_mitm_frame_modifier_if.slave bus
);
  localparam int                PW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0]       OCC_ONE  = 1;
  localparam logic [PW:0]       OCC_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]     PTR_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  localparam logic [2:0] MODE_SUB   = 3'd1;
  localparam logic [2:0] MODE_BLOCK = 3'd2;
  localparam logic [2:0] MODE_ROT13 = 3'd3;
  localparam logic [2:0] MODE_XOR   = 3'd4;

  logic       r_sess_prev;
  logic [2:0] r_mode;
  logic       w_start;

  logic [NUM_CHANNELS-1:0]               w_out_valid;
  logic [NUM_CHANNELS*NUM_DATA_BITS-1:0] w_out_data;
  logic [NUM_CHANNELS-1:0]               w_overflow;
  logic [NUM_CHANNELS*CNT_WIDTH-1:0]     w_frame_cnt;

  assign w_start = bus.session_active & ~r_sess_prev;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sess_prev <= 1'b0;
      r_mode      <= 3'd0;
    end else begin
      r_sess_prev <= bus.session_active;
      if (w_start) r_mode <= bus.mode_sel;
    end
  end

  function automatic logic [7:0] rot13(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5a) return (b <= 8'h4d) ? b + 8'd13 : b - 8'd13;
    if (b >= 8'h61 && b <= 8'h7a) return (b <= 8'h6d) ? b + 8'd13 : b - 8'd13;
    return b;
  endfunction

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [NUM_DATA_BITS-1:0] w_din, w_rot, w_xf;
    logic                     w_mod, w_keep, w_rd, w_wr, w_full;

    logic [CNT_WIDTH-1:0]                       r_cnt;
    logic                                       r_stg_vld;
    logic [NUM_DATA_BITS-1:0]                   r_stg_data;
    logic [FIFO_DEPTH-1:0][NUM_DATA_BITS-1:0]   r_mem;
    logic [PW-1:0]                              r_wptr, r_rptr;
    logic [PW:0]                                r_occ;
    logic [NUM_DATA_BITS-1:0]                   r_last;
    logic                                       r_ovf;

    assign w_din = bus.in_data[c*NUM_DATA_BITS +: NUM_DATA_BITS];

    // ROT13 only touches the low byte; narrower frames fall back to forwarding.
    if (NUM_DATA_BITS >= 8) begin : g_rot
      always_comb begin
        w_rot      = w_din;
        w_rot[7:0] = rot13(w_din[7:0]);
      end
    end else begin : g_norot
      assign w_rot = w_din;
    end

    assign w_mod = bus.chan_mask[c] && (r_cnt >= bus.skip_frames);

    always_comb begin
      w_xf   = w_din;
      w_keep = 1'b1;
      if (w_mod) begin
        case (r_mode)
          MODE_SUB:   w_xf   = SUB_VALUE;
          MODE_BLOCK: w_keep = 1'b0;
          MODE_ROT13: w_xf   = w_rot;
          MODE_XOR:   w_xf   = w_din ^ XOR_MASK;
          default:    w_xf   = w_din;
        endcase
      end
    end

    assign w_full = (r_occ == OCC_FULL);
    assign w_rd   = (r_occ != '0) && bus.out_ready[c];
    // A full FIFO still accepts the write when the head leaves in the same cycle.
    assign w_wr   = r_stg_vld && (!w_full || w_rd);

    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt      <= '0;
        r_stg_vld  <= 1'b0;
        r_stg_data <= '0;
        r_mem      <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_occ      <= '0;
        r_last     <= '0;
        r_ovf      <= 1'b0;
      end else if (w_start) begin
        r_cnt      <= '0;
        r_stg_vld  <= 1'b0;
        r_stg_data <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_occ      <= '0;
        r_ovf      <= 1'b0;
      end else begin
        r_stg_vld  <= bus.in_valid[c] && w_keep;
        r_stg_data <= w_xf;
        if (bus.in_valid[c] && (r_cnt != '1)) r_cnt <= r_cnt + CNT_ONE;
        if (w_wr) begin
          r_mem[r_wptr] <= r_stg_data;
          r_wptr        <= r_wptr + PTR_ONE;
        end
        if (w_rd) begin
          r_last <= r_mem[r_rptr];
          r_rptr <= r_rptr + PTR_ONE;
        end
        case ({w_wr, w_rd})
          2'b10:   r_occ <= r_occ + OCC_ONE;
          2'b01:   r_occ <= r_occ - OCC_ONE;
          default: r_occ <= r_occ;
        endcase
        if (r_stg_vld && w_full && !w_rd) r_ovf <= 1'b1;
      end
    end

    assign w_out_valid[c] = (r_occ != '0);
    assign w_out_data[c*NUM_DATA_BITS +: NUM_DATA_BITS] = (r_occ != '0) ? r_mem[r_rptr] : r_last;
    assign w_overflow[c]  = r_ovf;
    assign w_frame_cnt[c*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
  end

  assign bus.out_valid   = w_out_valid;
  assign bus.out_data    = w_out_data;
  assign bus.active_mode = r_mode;
  assign bus.overflow    = w_overflow;
  assign bus.frame_cnt   = w_frame_cnt;
endmodule

// File: tb/tb_spi_mitm_frame_modifier.sv
// Directed bench for spi_mitm_frame_modifier with hand-computed expectations.
module tb_spi_mitm_frame_modifier;
  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  spi_mitm_frame_modifier_if #(.NUM_DATA_BITS(8), .NUM_CHANNELS(2), .CNT_WIDTH(8)) bus ();

  spi_mitm_frame_modifier dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input int c, input logic [7:0] d);
    bus.in_valid[c]        = 1'b1;
    bus.in_data[c*8 +: 8]  = d;
    step();
    bus.in_valid           = '0;
  endtask

  task automatic start(input logic [2:0] m);
    bus.session_active = 1'b0;
    step();
    bus.mode_sel       = m;
    bus.session_active = 1'b1;
    step();
  endtask

  initial begin
    bus.session_active = 1'b0;
    bus.mode_sel       = 3'd0;
    bus.chan_mask      = 2'b11;
    bus.skip_frames    = 8'd0;
    bus.in_valid       = '0;
    bus.in_data        = '0;
    bus.out_ready      = 2'b11;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_active_mode", 32'(bus.active_mode), 32'h0);
    chk("rst_overflow", 32'(bus.overflow), 32'h0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'h0);
    rst_n = 1'b1;

    // FWD session
    start(3'd0);
    send(0, 8'hca); step();
    chk("fwd_valid0", 32'(bus.out_valid), 32'h1);
    chk("fwd_data0", 32'(bus.out_data[7:0]), 32'hca);
    send(0, 8'h00); step();
    chk("fwd_data1", 32'(bus.out_data[7:0]), 32'h00);
    chk("fwd_valid1", 32'(bus.out_valid[0]), 32'h1);
    step();
    chk("fwd_drained", 32'(bus.out_valid), 32'h0);
    chk("fwd_cnt", 32'(bus.frame_cnt), 32'h0002);

    // SUB with mask and skip
    bus.chan_mask   = 2'b01;
    bus.skip_frames = 8'd1;
    start(3'd1);
    chk("sub_mode", 32'(bus.active_mode), 32'h1);
    send(0, 8'h9b); step();
    chk("sub_skip", 32'(bus.out_data[7:0]), 32'h9b);
    send(0, 8'h38); step();
    chk("sub_repl", 32'(bus.out_data[7:0]), 32'h00);
    send(1, 8'h26); step();
    chk("sub_ch1_valid", 32'(bus.out_valid[1]), 32'h1);
    chk("sub_ch1_fwd", 32'(bus.out_data[15:8]), 32'h26);
    chk("sub_cnt", 32'(bus.frame_cnt), 32'h0102);

    // ROT13
    bus.chan_mask   = 2'b11;
    bus.skip_frames = 8'd0;
    start(3'd3);
    chk("rot_mode", 32'(bus.active_mode), 32'h3);
    send(0, 8'h48); step();
    chk("rot_H", 32'(bus.out_data[7:0]), 32'h55);
    send(0, 8'h7a); step();
    chk("rot_z", 32'(bus.out_data[7:0]), 32'h6d);
    send(0, 8'h35); step();
    chk("rot_5", 32'(bus.out_data[7:0]), 32'h35);

    // XOR
    start(3'd4);
    send(0, 8'h0f); step();
    chk("xor_ch0", 32'(bus.out_data[7:0]), 32'hf0);
    send(1, 8'h3c); step();
    chk("xor_ch1", 32'(bus.out_data[15:8]), 32'hc3);

    // BLOCK on ch1 only
    bus.chan_mask = 2'b10;
    start(3'd2);
    send(1, 8'h4f); step();
    chk("blk_v0", 32'(bus.out_valid[1]), 32'h0);
    send(1, 8'h68); step();
    chk("blk_v1", 32'(bus.out_valid[1]), 32'h0);
    send(1, 8'h69); step();
    chk("blk_v2", 32'(bus.out_valid[1]), 32'h0);
    chk("blk_cnt1", 32'(bus.frame_cnt[15:8]), 32'h3);
    send(0, 8'h11); step();
    chk("blk_ch0", 32'(bus.out_data[7:0]), 32'h11);

    // Overflow: five frames into a depth-4 FIFO
    bus.chan_mask = 2'b11;
    start(3'd0);
    bus.out_ready = 2'b00;
    for (int i = 1; i <= 5; i++) send(0, 8'(i));
    step();
    chk("ovf_flag", 32'(bus.overflow), 32'h1);
    chk("ovf_head", 32'(bus.out_data[7:0]), 32'h01);
    bus.out_ready = 2'b11;
    step(); chk("ovf_h2", 32'(bus.out_data[7:0]), 32'h02);
    step(); chk("ovf_h3", 32'(bus.out_data[7:0]), 32'h03);
    step(); chk("ovf_h4", 32'(bus.out_data[7:0]), 32'h04);
    step(); chk("ovf_empty", 32'(bus.out_valid[0]), 32'h0);
    chk("ovf_sticky", 32'(bus.overflow), 32'h1);
    start(3'd0);
    chk("ovf_cleared", 32'(bus.overflow), 32'h0);

    // Full FIFO with a simultaneous read accepts the write
    bus.out_ready = 2'b00;
    for (int i = 1; i <= 4; i++) send(0, 8'(8'ha0 + i));
    step();
    send(0, 8'ha5);
    bus.out_ready = 2'b11;
    step();
    chk("fr_noovf", 32'(bus.overflow), 32'h0);
    chk("fr_h2", 32'(bus.out_data[7:0]), 32'ha2);
    step(); chk("fr_h3", 32'(bus.out_data[7:0]), 32'ha3);
    step(); chk("fr_h4", 32'(bus.out_data[7:0]), 32'ha4);
    step(); chk("fr_h5", 32'(bus.out_data[7:0]), 32'ha5);
    step(); chk("fr_empty", 32'(bus.out_valid[0]), 32'h0);
    chk("fr_hold", 32'(bus.out_data[7:0]), 32'ha5);

    // Mid-session mode change is ignored; reset mid-session clears everything
    bus.chan_mask = 2'b01;
    start(3'd4);
    bus.mode_sel = 3'd1;
    step();
    chk("mid_mode", 32'(bus.active_mode), 32'h4);
    send(0, 8'h0f); step();
    chk("mid_xor", 32'(bus.out_data[7:0]), 32'hf0);
    bus.out_ready = 2'b00;
    send(0, 8'h12); step();
    chk("mid_valid", 32'(bus.out_valid[0]), 32'h1);
    #2;
    rst_n              = 1'b0;
    bus.session_active = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_mode", 32'(bus.active_mode), 32'h0);
    chk("mid_rst_cnt", 32'(bus.frame_cnt), 32'h0);
    chk("mid_rst_data", 32'(bus.out_data), 32'h0);
    #3;
    rst_n = 1'b1;
    step();
    chk("post_rst_mode", 32'(bus.active_mode), 32'h0);

    // Mode 5 behaves as forward
    bus.out_ready = 2'b11;
    start(3'd5);
    chk("m5_mode", 32'(bus.active_mode), 32'h5);
    send(0, 8'h0f); step();
    chk("m5_fwd", 32'(bus.out_data[7:0]), 32'h0f);

    // Frame counter saturation
    start(3'd0);
    for (int i = 0; i < 260; i++) send(0, 8'(i));
    chk("cnt_sat", 32'(bus.frame_cnt[7:0]), 32'hff);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
